// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction in flight,
// data-first arbitration with a bounded-wait counter that forces fetch through after MAX_WAIT losses.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_maskmode,
  input  logic                  d_sext,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]            mem_maskmode,
  output logic                  mem_sext,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_e;
  state_e                state_q;
  logic                  own_d_q, we_q, sext_q;
  logic [1:0]            mask_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  idle, issue, resp, pick_if;
  always_comb begin
    idle         = state_q == IDLE;
    issue        = state_q == ISSUE;
    resp         = state_q == RESP;
    pick_if      = if_req && (!d_req || cnt_q == CW'(MAX_WAIT));
    if_gnt       = idle && pick_if;
    d_gnt        = idle && d_req && !pick_if;
    cnt_d        = if_gnt ? '0 : (d_gnt && if_req && cnt_q != CW'(MAX_WAIT)) ? cnt_q + 1'b1 : cnt_q;
    busy         = !idle;
    mem_valid    = issue;
    mem_we       = issue && we_q;
    mem_sext     = issue && sext_q;
    mem_maskmode = issue ? mask_q : 2'b00;
    mem_addr     = issue ? addr_q : '0;
    mem_wdata    = issue ? wdata_q : '0;
    if_rvalid    = resp && !own_d_q;
    d_rvalid     = resp && own_d_q;
    if_rdata     = if_rvalid ? rdata_q : '0;
    d_rdata      = d_rvalid ? rdata_q : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      own_d_q <= 1'b0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      mask_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: if (if_gnt || d_gnt) begin
          own_d_q <= d_gnt;
          we_q    <= d_gnt && d_we;
          sext_q  <= d_gnt && d_sext;
          mask_q  <= d_gnt ? d_maskmode : 2'b10;
          addr_q  <= d_gnt ? d_addr : if_addr;
          wdata_q <= d_gnt ? d_wdata : '0;
          state_q <= ISSUE;
        end
        ISSUE: if (mem_ready) begin
          rdata_q <= we_q ? '0 : mem_rdata;
          state_q <= (we_q || mem_rvalid) ? RESP : WAIT_R;
        end
        WAIT_R: if (mem_rvalid) begin
          rdata_q <= mem_rdata;
          state_q <= RESP;
        end
        RESP: state_q <= IDLE;
      endcase
    end
  end
endmodule
